// File: rtl/cache_mem_pkg.sv
// rtl/cache_mem_pkg.sv - shared FSM/op types, line geometry and line-base helper
package cache_mem_pkg;

  localparam int WORDS_PER_LINE  = 4;
  localparam int OFFSET_W        = $clog2(WORDS_PER_LINE);
  localparam int LATENCY_DEFAULT = 20;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WBURST,
    DONE
  } mem_state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } mem_op_e;

  // Clear the in-line word offset so the burst always starts at word 0.
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int offset_w);
    logic [63:0] mask;
    mask = ~((64'd1 << offset_w) - 64'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous RAM, one-cycle read latency, no reset
module mem_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write or read one word per enabled cycle; the read register holds between reads.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/line_fill_memory.sv
// rtl/line_fill_memory.sv - latency-modelled line-fill / write-back memory controller
module line_fill_memory
  import cache_mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = cache_mem_pkg::WORDS_PER_LINE,
  parameter int LATENCY        = LATENCY_DEFAULT,
  parameter int DEPTH          = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_mem,
  input  logic              write_mem,
  input  logic [ADDR_W-1:0] addr_mem,
  input  logic [DATA_W-1:0] wdata_mem,
  output logic [DATA_W-1:0] rdata_mem,
  output logic              rvalid_mem,
  output logic              ready_mem
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LAT_W = $clog2(LATENCY + 1);

  mem_state_e        state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [IDX_W-1:0]  base_q, base_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic              ready_q, ready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] hold_q, hold_d;

  logic [63:0]       req_base;
  logic              unused_req_hi;
  logic              last_beat;
  logic              ram_en, ram_we;
  logic [OFF_W-1:0]  ram_off;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign req_base      = line_base(64'(addr_mem), OFF_W);
  assign unused_req_hi = ^req_base[63:IDX_W];
  assign last_beat     = (beat_q == OFF_W'(WORDS_PER_LINE - 1));

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    base_d  = base_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (write_mem || read_mem) begin
          op_d    = write_mem ? OP_WR : OP_RD;
          base_d  = req_base[IDX_W-1:0];
          lat_d   = LAT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = (op_q == OP_RD) ? RBURST : WBURST;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      RBURST, WBURST: begin
        beat_d = beat_q + OFF_W'(1);
        if (last_beat) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!read_mem && !write_mem) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d  = (state_d != WAIT);
    rvalid_d = (state_d == RBURST);
    hold_d   = rvalid_q ? ram_rdata : hold_q;
  end

  // RAM port: word 0 is read in the last WAIT cycle, word k+1 during read beat k.
  always_comb begin
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    ram_off = beat_q;
    case (state_q)
      WAIT: begin
        ram_en  = (lat_q == '0) && (op_q == OP_RD);
        ram_off = '0;
      end
      RBURST: begin
        ram_en  = !last_beat;
        ram_off = beat_q + OFF_W'(1);
      end
      WBURST: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
    ram_addr = {base_q[IDX_W-1:OFF_W], ram_off};
  end

  // FSM, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= OP_RD;
      base_q   <= '0;
      lat_q    <= '0;
      beat_q   <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      base_q   <= base_d;
      lat_q    <= lat_d;
      beat_q   <= beat_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      hold_q   <= hold_d;
    end
  end

  mem_array #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata_mem),
    .rdata(ram_rdata)
  );

  assign ready_mem  = ready_q;
  assign rvalid_mem = rvalid_q;
  assign rdata_mem  = rvalid_q ? ram_rdata : hold_q;

endmodule
